// File: rtl/accel_pkg.sv
// Shared constants for the accelerometer tilt filter: sample width and tilt codes.
package accel_pkg;

  localparam int ACCEL_W = 16;

  localparam logic [1:0] TILT_LEVEL = 2'b00;
  localparam logic [1:0] TILT_LEFT  = 2'b01;
  localparam logic [1:0] TILT_RIGHT = 2'b10;

endpackage

// File: rtl/accel_tilt_filter_if.sv
// Sample-in / average-out bundle of the tilt filter; the filter takes the slave side.
interface accel_tilt_filter_if;
  import accel_pkg::*;

  logic                      sample_valid;
  logic signed [ACCEL_W-1:0] y_raw;
  logic signed [ACCEL_W-1:0] z_raw;
  logic signed [ACCEL_W-1:0] y_avg;
  logic signed [ACCEL_W-1:0] z_avg;
  logic                      avg_valid;
  logic                      filled;
  logic [1:0]                tilt;

  modport master (
    output sample_valid, y_raw, z_raw,
    input  y_avg, z_avg, avg_valid, filled, tilt
  );

  modport slave (
    input  sample_valid, y_raw, z_raw,
    output y_avg, z_avg, avg_valid, filled, tilt
  );

endinterface

// File: rtl/accel_ring_avg.sv
// One-axis boxcar average: ring buffer + running sum, 2-cycle pipeline from in_valid to out_valid.
module accel_ring_avg
  import accel_pkg::*;
#(
  parameter int LOG2_DEPTH = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic signed [ACCEL_W-1:0] in_data,
  output logic                      out_valid,
  output logic signed [ACCEL_W-1:0] out_avg
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = ACCEL_W + LOG2_DEPTH;

  logic signed [ACCEL_W-1:0] ring [DEPTH];
  logic [LOG2_DEPTH-1:0]     wr_ptr;
  logic signed [ACCEL_W-1:0] new_q;
  logic signed [ACCEL_W-1:0] old_q;
  logic                      stage1_valid;
  logic signed [SUM_W-1:0]   sum_q;
  logic signed [SUM_W-1:0]   sum_next;

  assign sum_next = sum_q + {{LOG2_DEPTH{new_q[ACCEL_W-1]}}, new_q}
                          - {{LOG2_DEPTH{old_q[ACCEL_W-1]}}, old_q};

  // Power-of-two depth lets the pointer wrap by plain overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      new_q        <= '0;
      old_q        <= '0;
      stage1_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
    end else begin
      stage1_valid <= in_valid;
      if (in_valid) begin
        ring[wr_ptr] <= in_data;
        new_q        <= in_data;
        old_q        <= ring[wr_ptr];
        wr_ptr       <= wr_ptr + 1'b1;
      end
    end
  end

  // Dropping the low LOG2_DEPTH bits of the signed sum is the floor-toward-minus-infinity divide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q     <= '0;
      out_avg   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= stage1_valid;
      if (stage1_valid) begin
        sum_q   <= sum_next;
        out_avg <= sum_next[SUM_W-1:LOG2_DEPTH];
      end
    end
  end

endmodule

// File: rtl/accel_tilt_filter.sv
// Y/Z moving-average filter with tilt classification on the filtered Y axis.
// Define ACCEL_TILT_HYST_EN to make tilt stateful with a HYST-wide release band.
module accel_tilt_filter
  import accel_pkg::*;
#(
  parameter int         LOG2_DEPTH = 3,
  parameter logic [15:0] THRESH    = 16'd200,
  parameter logic [15:0] HYST      = 16'd40
) (
  input logic            clk,
  input logic            reset,
  accel_tilt_filter_if.slave bus
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0]  CNT_MAX  = (LOG2_DEPTH + 1)'(DEPTH);
  localparam logic [LOG2_DEPTH:0]  CNT_LAST = CNT_MAX - 1'b1;
  localparam logic signed [16:0]   THR_P    = {1'b0, THRESH};
  localparam logic signed [16:0]   THR_N    = -THR_P;
  localparam logic signed [16:0]   REL_P    = THR_P - {1'b0, HYST};
  localparam logic signed [16:0]   REL_N    = -REL_P;

  logic                      y_valid;
  logic                      z_valid;
  logic signed [ACCEL_W-1:0] y_avg;
  logic signed [ACCEL_W-1:0] z_avg;
  logic [LOG2_DEPTH:0]       cnt;
  logic                      fill_pend;
  logic                      filled;
  logic signed [16:0]        y_ext;
  logic [1:0]                tilt_prev;
  logic [1:0]                tilt_now;

  accel_ring_avg #(.LOG2_DEPTH(LOG2_DEPTH)) u_y_avg (
    .clk      (clk),
    .reset    (reset),
    .in_valid (bus.sample_valid),
    .in_data  (bus.y_raw),
    .out_valid(y_valid),
    .out_avg  (y_avg)
  );

  accel_ring_avg #(.LOG2_DEPTH(LOG2_DEPTH)) u_z_avg (
    .clk      (clk),
    .reset    (reset),
    .in_valid (bus.sample_valid),
    .in_data  (bus.z_raw),
    .out_valid(z_valid),
    .out_avg  (z_avg)
  );

  // From level this is the plain threshold rule, so the stateless build just pins prev to level.
  function automatic logic [1:0] classify(logic signed [16:0] y, logic [1:0] prev);
    logic [1:0] t;
    t = prev;
    case (prev)
      TILT_RIGHT: begin
        if (y < THR_N)      t = TILT_LEFT;
        else if (y < REL_P) t = TILT_LEVEL;
      end
      TILT_LEFT: begin
        if (y > THR_P)      t = TILT_RIGHT;
        else if (y > REL_N) t = TILT_LEVEL;
      end
      default: begin
        if (y > THR_P)      t = TILT_RIGHT;
        else if (y < THR_N) t = TILT_LEFT;
        else                t = TILT_LEVEL;
      end
    endcase
    return t;
  endfunction

  assign y_ext    = {y_avg[ACCEL_W-1], y_avg};
  assign tilt_now = classify(y_ext, tilt_prev);

`ifdef ACCEL_TILT_HYST_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              tilt_prev <= TILT_LEVEL;
    else if (bus.avg_valid) tilt_prev <= tilt_now;
  end
`else
  assign tilt_prev = TILT_LEVEL;
`endif

  // fill_pend rides alongside the averaging pipeline so filled rises with sample #DEPTH's result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      fill_pend <= 1'b0;
      filled    <= 1'b0;
    end else begin
      fill_pend <= bus.sample_valid && (cnt == CNT_LAST);
      if (bus.sample_valid && (cnt != CNT_MAX)) cnt <= cnt + 1'b1;
      if (fill_pend) filled <= 1'b1;
    end
  end

  assign bus.y_avg     = y_avg;
  assign bus.z_avg     = z_avg;
  assign bus.avg_valid = y_valid & z_valid;
  assign bus.filled    = filled;
  assign bus.tilt      = tilt_now;

endmodule

// File: tb/tb_accel_tilt_filter.sv
// Scoreboard bench for accel_tilt_filter: window-average reference model, monitor pops on avg_valid.
module tb_accel_tilt_filter;
  import accel_pkg::*;

  localparam int L = 3;
  localparam int D = 1 << L;
  localparam int T = 200;
  localparam int H = 40;

  typedef struct {
    int y;
    int z;
    int tilt;
    int filled;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   av_seen = 0;

  exp_t sb[$];
  int   hist_y[$];
  int   hist_z[$];
  int   m_count;
  int   m_tilt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  accel_tilt_filter_if bus();

  accel_tilt_filter #(.LOG2_DEPTH(L), .THRESH(16'd200), .HYST(16'd40)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic checkOutput(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int floorDiv(int s);
    if (s >= 0) return s / D;
    return -((-s + D - 1) / D);
  endfunction

  function automatic int sumOf(int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  // Tilt rules written straight from the level/left/right definitions.
  function automatic int nextTilt(int a, int prev);
`ifdef ACCEL_TILT_HYST_EN
    if (prev == 2) begin
      if (a < -T) return 1;
      if (a < T - H) return 0;
      return 2;
    end
    if (prev == 1) begin
      if (a > T) return 2;
      if (a > -(T - H)) return 0;
      return 1;
    end
`endif
    if (a > T) return 2;
    if (a < -T) return 1;
    return 0;
  endfunction

  task automatic modelReset();
    hist_y = {};
    hist_z = {};
    for (int i = 0; i < D; i++) begin
      hist_y.push_back(0);
      hist_z.push_back(0);
    end
    m_count = 0;
    m_tilt  = 0;
    sb.delete();
  endtask

  task automatic applyReset();
    reset = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one strobe and records what the window should look like afterwards.
  task automatic applyStimulus(int y, int z);
    exp_t e;
    int   ay;
    hist_y.push_back(y);
    void'(hist_y.pop_front());
    hist_z.push_back(z);
    void'(hist_z.pop_front());
    ay = floorDiv(sumOf(hist_y));
    m_tilt = nextTilt(ay, m_tilt);
    if (m_count < D) m_count++;
    e.y      = ay;
    e.z      = floorDiv(sumOf(hist_z));
    e.tilt   = m_tilt;
    e.filled = (m_count >= D) ? 1 : 0;
    e.due    = cyc + 2;
    sb.push_back(e);
    bus.sample_valid = 1'b1;
    bus.y_raw        = 16'(y);
    bus.z_raw        = 16'(z);
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
  endtask

  // Monitor: every avg_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && bus.avg_valid) begin
      av_seen++;
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_avg_valid: got avg_valid=1, expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("y_avg", int'(bus.y_avg), e.y);
        checkOutput("z_avg", int'(bus.z_avg), e.z);
        checkOutput("tilt", int'(bus.tilt), e.tilt);
        checkOutput("filled", int'(bus.filled), e.filled);
        checkOutput("latency", cyc, e.due);
      end
    end
  end

  initial begin
    int sweep_val[4];
    int sweep_tilt[4];
    int y;
    int z;
    sweep_val = '{0, 250, 180, 150};
`ifdef ACCEL_TILT_HYST_EN
    sweep_tilt = '{0, 2, 2, 0};
`else
    sweep_tilt = '{0, 2, 0, 0};
`endif
    bus.sample_valid = 1'b0;
    bus.y_raw        = '0;
    bus.z_raw        = '0;
    applyReset();

    idle(100);
    checkOutput("rst_y_avg", int'(bus.y_avg), 0);
    checkOutput("rst_z_avg", int'(bus.z_avg), 0);
    checkOutput("rst_avg_valid", int'(bus.avg_valid), 0);
    checkOutput("rst_filled", int'(bus.filled), 0);
    checkOutput("rst_tilt", int'(bus.tilt), 0);
    checkOutput("rst_no_pulses", av_seen, 0);

    for (int i = 0; i < D; i++) applyStimulus(800, -80);
    idle(3);
    checkOutput("burst_y_final", int'(bus.y_avg), 800);
    checkOutput("burst_z_final", int'(bus.z_avg), -80);
    checkOutput("burst_filled", int'(bus.filled), 1);

    applyReset();
    applyStimulus(-1, 0);
    idle(3);
    checkOutput("floor_first", int'(bus.y_avg), -1);
    for (int i = 0; i < D - 1; i++) applyStimulus(0, 0);
    idle(3);
    checkOutput("floor_held", int'(bus.y_avg), -1);
    applyStimulus(0, 0);
    idle(3);
    checkOutput("floor_evicted", int'(bus.y_avg), 0);

    applyReset();
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < D; i++) applyStimulus(sweep_val[s], 0);
      idle(3);
      checkOutput("sweep_y", int'(bus.y_avg), sweep_val[s]);
      checkOutput("sweep_tilt", int'(bus.tilt), sweep_tilt[s]);
    end

    applyReset();
    av_seen = 0;
    for (int i = 0; i < 20; i++) applyStimulus((i % 2 == 0) ? 1000 : -1000, 0);
    idle(4);
    checkOutput("b2b_pulses", av_seen, 20);
    checkOutput("b2b_y", int'(bus.y_avg), 0);
    checkOutput("b2b_tilt", int'(bus.tilt), 0);

    applyReset();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(1) == 0) begin
        y = int'($signed(16'($urandom)));
        z = int'($signed(16'($urandom)));
      end else begin
        y = int'($urandom_range(600)) - 300;
        z = int'($urandom_range(200)) - 100;
      end
      applyStimulus(y, z);
      if ($urandom_range(3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(4);

    applyStimulus(100, 5);
    reset = 1'b1;
    modelReset();
    av_seen = 0;
    idle(2);
    reset = 1'b0;
    idle(5);
    checkOutput("midrst_no_pulse", av_seen, 0);
    applyStimulus(800, 0);
    idle(3);
    checkOutput("midrst_y", int'(bus.y_avg), 100);
    checkOutput("midrst_filled", int'(bus.filled), 0);

    idle(5);
    checkOutput("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
